// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multichannel PWM generator.
package pwm_pkg;

    localparam int PWM_NUM_CH_DEF = 4;
    localparam int PWM_CNT_W_DEF  = 16;

    typedef enum logic {
        ALIGN_EDGE   = 1'b0,
        ALIGN_CENTER = 1'b1
    } pwm_align_e;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: duty compare against the shared counter, polarity and output register.
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_invert,
    output logic             o_pwm
);

    logic w_raw;
    logic r_pwm;

    assign w_raw = (i_cnt < i_duty);

    // While disabled the pin rests at its idle level, which is the polarity bit itself.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pwm <= 1'b0;
        end else if (!i_enable) begin
            r_pwm <= i_invert;
        end else begin
            r_pwm <= w_raw ^ i_invert;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator: shared edge/centre-aligned counter with shadowed configuration.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = PWM_NUM_CH_DEF,
    parameter int CNT_W  = PWM_CNT_W_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [NUM_CH*CNT_W-1:0] i_duty,
    input  logic                    i_center_mode,
    input  logic [NUM_CH-1:0]       i_invert,
    output logic [NUM_CH-1:0]       o_pwm_out,
    output logic                    o_period_end
);

    typedef struct packed {
        logic [CNT_W-1:0]             period;
        logic [NUM_CH-1:0][CNT_W-1:0] duty;
        pwm_align_e                   mode;
        logic [NUM_CH-1:0]            invert;
    } pwm_cfg_t;

    pwm_cfg_t   r_active;
    pwm_cfg_t   r_pending;
    logic       r_pending_valid;
    logic [CNT_W-1:0] r_cnt;
    pwm_dir_e   r_state;
    logic       r_period_end;

    pwm_cfg_t   w_load_cfg;
    logic       w_boundary;
    logic       w_apply;

    always_comb begin
        w_load_cfg        = '0;
        w_load_cfg.period = i_period;
        w_load_cfg.duty   = i_duty;
        w_load_cfg.mode   = i_center_mode ? ALIGN_CENTER : ALIGN_EDGE;
        w_load_cfg.invert = i_invert;
    end

    // Centre periods of 0 or 1 never enter the down leg, so their last cycle is cnt==P.
    always_comb begin
        w_boundary = 1'b0;
        if (r_active.mode == ALIGN_EDGE) begin
            w_boundary = (r_cnt == r_active.period);
        end else if (r_active.period <= CNT_W'(1)) begin
            w_boundary = (r_cnt == r_active.period);
        end else begin
            w_boundary = (r_state == CNT_DOWN) && (r_cnt == CNT_W'(1));
        end
    end

    assign w_apply = !i_enable || w_boundary;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_state      <= CNT_UP;
            r_period_end <= 1'b0;
        end else if (!i_enable) begin
            r_cnt        <= '0;
            r_state      <= CNT_UP;
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= w_boundary;
            if (w_boundary) begin
                r_cnt   <= '0;
                r_state <= CNT_UP;
            end else begin
                case (r_state)
                    CNT_UP: begin
                        if (r_active.mode == ALIGN_CENTER && r_cnt == r_active.period) begin
                            r_state <= CNT_DOWN;
                            r_cnt   <= r_cnt - CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    CNT_DOWN: r_cnt <= r_cnt - CNT_W'(1);
                    default:  r_state <= CNT_UP;
                endcase
            end
        end
    end

    // A load landing on an apply cycle bypasses the pending registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_apply) begin
            if (i_load) begin
                r_active <= w_load_cfg;
            end else if (r_pending_valid) begin
                r_active <= r_pending;
            end
            r_pending_valid <= 1'b0;
        end else if (i_load) begin
            r_pending       <= w_load_cfg;
            r_pending_valid <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_compare_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_enable (i_enable),
            .i_cnt    (r_cnt),
            .i_duty   (r_active.duty[g]),
            .i_invert (r_active.invert[g]),
            .o_pwm    (o_pwm_out[g])
        );
    end

    assign o_period_end = r_period_end;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomised bench for pwm_multichannel against a phase-based reference model.
module tb_pwm_multichannel;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            load;
    logic [CW-1:0]   period;
    logic [NCH*CW-1:0] duty;
    logic            centerMode;
    logic [NCH-1:0]  invert;
    logic [NCH-1:0]  pwmOut;
    logic            periodEnd;
    logic [0:0]      pwmOut8;
    logic            periodEnd8;

    int totalCount = 0;
    int badCount   = 0;

    always #5 clock = ~clock;

    pwm_multichannel #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_load        (load),
        .i_period      (period),
        .i_duty        (duty),
        .i_center_mode (centerMode),
        .i_invert      (invert),
        .o_pwm_out     (pwmOut),
        .o_period_end  (periodEnd)
    );

    // Narrow single-channel build driven with channel 0's settings.
    pwm_multichannel #(.NUM_CH(1), .CNT_W(8)) dutSmall (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_load        (load),
        .i_period      (period[7:0]),
        .i_duty        (duty[7:0]),
        .i_center_mode (centerMode),
        .i_invert      (invert[0:0]),
        .o_pwm_out     (pwmOut8),
        .o_period_end  (periodEnd8)
    );

    typedef struct {
        int       per;
        int       dty[NCH];
        bit       ctr;
        bit [NCH-1:0] inv;
    } cfg_t;

    cfg_t   mAct;
    cfg_t   mPend;
    bit     mPendValid;
    int     mPhase;
    logic [NCH-1:0] expOut;
    logic   expEnd;

    function automatic cfg_t zeroCfg();
        cfg_t c;
        c.per = 0;
        foreach (c.dty[i]) c.dty[i] = 0;
        c.ctr = 1'b0;
        c.inv = '0;
        return c;
    endfunction

    function automatic cfg_t inputCfg();
        cfg_t c;
        c.per = int'(period);
        foreach (c.dty[i]) c.dty[i] = int'(duty[i*CW +: CW]);
        c.ctr = centerMode;
        c.inv = invert;
        return c;
    endfunction

    // Length of one PWM period in clocks.
    function automatic int periodLen(cfg_t c);
        if (!c.ctr) return c.per + 1;
        if (c.per == 0) return 1;
        return 2 * c.per;
    endfunction

    // Counter value seen at a given position inside the period (triangle in centre mode).
    function automatic int cntAtPhase(cfg_t c, int k);
        if (!c.ctr || k <= c.per) return k;
        return 2 * c.per - k;
    endfunction

    task automatic modelStep();
        cfg_t inCfg;
        int   c;
        bit   last;
        inCfg = inputCfg();
        if (reset) begin
            mAct = zeroCfg();
            mPend = zeroCfg();
            mPendValid = 1'b0;
            mPhase = 0;
            expOut = '0;
            expEnd = 1'b0;
        end else if (!enable) begin
            expOut = mAct.inv;
            expEnd = 1'b0;
            mPhase = 0;
            if (load) mAct = inCfg;
            else if (mPendValid) mAct = mPend;
            mPendValid = 1'b0;
        end else begin
            c = cntAtPhase(mAct, mPhase);
            for (int i = 0; i < NCH; i++) expOut[i] = (c < mAct.dty[i]) ^ mAct.inv[i];
            last = (mPhase == periodLen(mAct) - 1);
            expEnd = last;
            if (last) begin
                mPhase = 0;
                if (load) mAct = inCfg;
                else if (mPendValid) mAct = mPend;
                mPendValid = 1'b0;
            end else begin
                mPhase++;
                if (load) begin
                    mPend = inCfg;
                    mPendValid = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    // One clock: model predicts, edge happens, registered outputs are compared.
    task automatic applyStimulus();
        modelStep();
        @(posedge clock);
        #1;
        checkOutput("pwm", 32'(pwmOut), 32'(expOut));
        checkOutput("end", 32'(periodEnd), 32'(expEnd));
        checkOutput("pwm8", 32'(pwmOut8), 32'(expOut[0]));
        checkOutput("end8", 32'(periodEnd8), 32'(expEnd));
    endtask

    task automatic setCfg(input int p, input int d0, input int d1, input int d2, input int d3,
                          input bit ctr, input logic [NCH-1:0] inv);
        period = CW'(p);
        duty = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
        centerMode = ctr;
        invert = inv;
    endtask

    task automatic loadCfg(input int p, input int d0, input int d1, input int d2, input int d3,
                           input bit ctr, input logic [NCH-1:0] inv);
        setCfg(p, d0, d1, d2, d3, ctr, inv);
        load = 1'b1;
        applyStimulus();
        load = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        load = 1'b0;
        setCfg(0, 0, 0, 0, 0, 1'b0, '0);
        runCycles(2);
        reset = 1'b0;

        $display("[TB] edge P=9 mixed duties");
        loadCfg(9, 3, 0, 10, 5, 1'b0, 4'b0000);
        enable = 1'b1;
        runCycles(25);

        $display("[TB] centre P=8");
        loadCfg(8, 4, 2, 9, 8, 1'b1, 4'b0000);
        runCycles(40);

        $display("[TB] mid-period load");
        loadCfg(9, 3, 3, 3, 3, 1'b0, 4'b0000);
        runCycles(30);
        loadCfg(9, 7, 3, 3, 3, 1'b0, 4'b0000);
        runCycles(25);

        $display("[TB] load on boundary and double load");
        while (!(mPhase == periodLen(mAct) - 1)) applyStimulus();
        loadCfg(5, 2, 4, 6, 1, 1'b0, 4'b0000);
        runCycles(3);
        loadCfg(7, 1, 1, 1, 1, 1'b0, 4'b0000);
        loadCfg(6, 5, 0, 2, 3, 1'b0, 4'b0000);
        runCycles(20);

        $display("[TB] invert while idle");
        enable = 1'b0;
        loadCfg(9, 3, 0, 10, 5, 1'b0, 4'b0101);
        runCycles(6);
        enable = 1'b1;
        runCycles(25);

        $display("[TB] reset mid-period in centre mode");
        loadCfg(8, 4, 3, 2, 1, 1'b1, 4'b0000);
        runCycles(25);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        runCycles(5);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            int p;
            reset = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 19) != 0);
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                p = $urandom_range(0, 12);
                setCfg(p, $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                       $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
            applyStimulus();
        end
        reset = 1'b0;
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
